// File: rtl/io_pattern_exerciser.sv
// Multi-channel IO exerciser: drives an LFSR pattern onto pad buffers,
// sets the tristate controls per test mode and checks pad_i against the
// expected vector in loopback/input modes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; pads released, error results held
// DRIVE  | present expected vector on pad_o, pad_t set per mode
// WAIT   | hold pads for SETTLE cycles of round-trip latency
// SAMPLE | compare pad_i (LOOP/IN), step LFSR and vector count
// DONE   | one-cycle done pulse, pads released
module io_pattern_exerciser #(
    parameter int          CHANNELS    = 8,
    parameter int          NUM_VECTORS = 64,
    parameter int          SETTLE      = 2,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          ERR_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] pad_o,
    output logic [CHANNELS-1:0] pad_t,
    input  logic [CHANNELS-1:0] pad_i,
    output logic                busy,
    output logic                done,
    output logic [ERR_W-1:0]    err_count,
    output logic [CHANNELS-1:0] err_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [1:0]  MODE_OUT  = 2'd0;
    localparam logic [1:0]  MODE_TRI  = 2'd1;
    localparam logic [1:0]  MODE_LOOP = 2'd2;
    localparam logic [1:0]  MODE_IN   = 2'd3;
    localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);
    // Wait counter counts down to zero, so it is loaded with SETTLE-1.
    localparam logic [7:0]  SETTLE_LD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    state_t                state_q;
    logic [1:0]            mode_q;
    logic [15:0]           lfsr_q;
    logic [15:0]           vcnt_q;
    logic [7:0]            wcnt_q;
    logic [CHANNELS-1:0]   pad_o_q;
    logic [CHANNELS-1:0]   pad_t_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ERR_W-1:0]      err_count_q;
    logic [CHANNELS-1:0]   err_mask_q;

    logic [15:0]           lfsr_d;
    logic [15:0]           vcnt_d;
    logic [ERR_W-1:0]      err_count_d;
    logic [CHANNELS-1:0]   diff;
    logic                  check_en;

    // Tristate pattern for a vector: TRI mode floats the pads on odd vectors.
    function automatic logic [CHANNELS-1:0] tri_mask(input logic [1:0] m, input logic odd);
        logic [CHANNELS-1:0] t;
        t = '0;
        case (m)
            MODE_TRI: t = odd ? '1 : '0;
            MODE_IN:  t = '1;
            default:  t = '0;
        endcase
        return t;
    endfunction

    // Next LFSR value, vector count and saturating error count.
    always_comb begin
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        vcnt_d      = vcnt_q + 16'd1;
        diff        = pad_i ^ lfsr_q[CHANNELS-1:0];
        check_en    = (mode_q == MODE_LOOP) || (mode_q == MODE_IN);
        err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + ERR_W'(1);
    end

    // Sequencer with registered pad controls, status and error results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_OUT;
            lfsr_q      <= SEED;
            vcnt_q      <= '0;
            wcnt_q      <= '0;
            pad_o_q     <= '0;
            pad_t_q     <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            err_mask_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_DRIVE;
                        mode_q      <= mode;
                        lfsr_q      <= SEED;
                        vcnt_q      <= '0;
                        err_count_q <= '0;
                        err_mask_q  <= '0;
                        pad_o_q     <= SEED[CHANNELS-1:0];
                        pad_t_q     <= tri_mask(mode, 1'b0);
                        busy_q      <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (SETTLE > 0) begin
                        state_q <= S_WAIT;
                        wcnt_q  <= SETTLE_LD;
                    end else begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == 8'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        wcnt_q <= wcnt_q - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (check_en && (diff != '0)) begin
                        err_count_q <= err_count_d;
                        err_mask_q  <= err_mask_q | diff;
                    end
                    lfsr_q <= lfsr_d;
                    vcnt_q <= vcnt_d;
                    if (vcnt_q == LAST_VEC) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pad_t_q <= '1;
                    end else begin
                        state_q <= S_DRIVE;
                        pad_o_q <= lfsr_d[CHANNELS-1:0];
                        pad_t_q <= tri_mask(mode_q, vcnt_d[0]);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pad_o     = pad_o_q;
    assign pad_t     = pad_t_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign err_mask  = err_mask_q;

endmodule

// File: doc/io_pattern_exerciser.md
Name: io_pattern_exerciser

Overview:
- Parametrised, clocked IO exerciser for LIFCL IO-mode characterisation.
- Drives CHANNELS pad buffers (PADDO/PADDT/PADDI) with an LFSR pattern, controls tristate per mode, and checks loopback or external input data.
- Sits between bitstream-level IO primitives (BB/OB/IB per channel) and a small test controller. Replaces the static single-output fixture with multi-channel, multi-mode, self-checking behaviour.

Parameters:
- CHANNELS, 8, number of pad channels (1..16).
- NUM_VECTORS, 64, vectors per run (1..65535).
- SETTLE, 2, wait cycles between drive and sample (0..255).
- SEED, 16'hACE1, LFSR seed (nonzero).
- ERR_W, 8, width of error counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE only.
- mode  in  2  0=OUT, 1=TRI, 2=LOOP, 3=IN; latched at start.
- pad_o  out  CHANNELS  to PADDO.
- pad_t  out  CHANNELS  to PADDT (1 = high-Z/input).
- pad_i  in  CHANNELS  from PADDI.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.
- err_count  out  ERR_W  mismatched vectors, saturating.
- err_mask  out  CHANNELS  sticky OR of per-channel mismatches.

Behaviour:
- Reset (asynchronous, active-low) sets all outputs to their idle values:
  - pad_o=0, pad_t=all ones, busy=0, done=0, err_count=0, err_mask=0.
  - LFSR=SEED, vector counter=0, state=IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - next = {b0^b2^b3^b5, lfsr[15:1]}.
  - Expected vector = lfsr[CHANNELS-1:0].
- States:
  - IDLE -> DRIVE when start=1.
    - Latches mode; clears err_count and err_mask; loads LFSR=SEED and vcnt=0.
    - busy rises in the next cycle.
  - DRIVE (1 cycle): pad_o=expected vector. pad_t per mode:
    - OUT: all zeros.
    - TRI: all ones if vcnt[0]=1, else all zeros.
    - LOOP: all zeros.
    - IN: all ones.
  - DRIVE -> WAIT if SETTLE>0, else -> SAMPLE.
  - WAIT: hold pad_o/pad_t for SETTLE cycles, then -> SAMPLE.
  - SAMPLE (1 cycle):
    - In LOOP or IN mode, compare pad_i to the expected vector. On mismatch: err_count += 1 (saturates at 2^ERR_W-1) and err_mask |= pad_i ^ expected.
    - No compare in OUT or TRI mode.
    - Step the LFSR and increment vcnt.
    - If vcnt == NUM_VECTORS-1: -> DONE. Otherwise -> DRIVE.
  - DONE (1 cycle): done=1, busy=0, pad_t=all ones, pad_o held. Then -> IDLE.
- Timing: each vector takes SETTLE+2 cycles, so a run takes NUM_VECTORS*(SETTLE+2)+1 cycles from start-accept to the done pulse.
- start while busy, or during the DONE cycle, is ignored. Changes to mode mid-run are ignored.
- err_count and err_mask hold their values in IDLE until the next accepted start.
- pad_i is assumed synchronous to clk. The block has no synchroniser; SETTLE covers pad round-trip latency.
- If reset is asserted mid-run, the block returns to reset values immediately; no done pulse is generated.
- SEED=0 is illegal and not guarded.

Test Plan:
- OUT mode, CHANNELS=8, SETTLE=0, NUM_VECTORS=3, start pulse -> pad_o sequence 0xE1, 0x70, then the next LFSR low byte; pad_t=0x00 in DRIVE; done after 7 cycles; err_count=0.
- LOOP mode, pad_i tied to pad_o with a 2-cycle delay, SETTLE=2 -> err_count=0, err_mask=0 after 64 vectors; done pulse width exactly 1 cycle.
- LOOP mode with pad_i[3] stuck at 0 -> err_mask=0x08, err_count equals the number of vectors with expected bit 3 = 1 (bench-computed model); saturation checked with ERR_W=2 -> 3.
- TRI mode -> pad_t alternates 0x00 (vcnt even) / 0xFF (vcnt odd) per vector; err_count stays 0 regardless of pad_i.
- rst_n pulled low during vector 10 of a LOOP run -> pad_t=0xFF and busy=0 asynchronously, no done pulse; a new start produces pad_o=0xE1 again.
- start held high through the run and mode changed mid-run -> exactly one run in the latched mode; a new run begins only after IDLE is re-entered.
